port0_out_ctrl: RTL and testbench

//   Output-side port controller for port 0; counterpart of the port 1 input path (p1Data).
//   The CPU control unit writes 16-bit words from the internal bus into a small FIFO.
//   The block presents them on p0_data_out to an external consumer using a valid/ack handshake.
//   A status word can be driven back onto the bus for polling.

---
 rtl/port0_out_ctrl_pkg.sv | 22 ++
 rtl/port0_out_ctrl_fifo.sv | 49 ++++
 rtl/port0_out_ctrl.sv | 77 +++++++
 tb/tb_port0_out_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/port0_out_ctrl_pkg.sv
// rtl/port0_out_ctrl_pkg.sv - shared constants and status packing for the port 0 output controller
package port0_out_ctrl_pkg;

  localparam int WORD_W_DEF       = 16;
  localparam int DEPTH_DEF        = 4;
  localparam int STATUS_OVF_BIT   = 15;
  localparam int STATUS_FULL_BIT  = 5;
  localparam int STATUS_EMPTY_BIT = 4;
  localparam logic [15:0] P0_CLR_OVF_WORD = 16'hFFFF;

  function automatic logic [15:0] pack_status(input logic ovf, input logic full,
                                              input logic empty, input logic [3:0] count);
    logic [15:0] s;
    s = '0;
    s[STATUS_OVF_BIT]   = ovf;
    s[STATUS_FULL_BIT]  = full;
    s[STATUS_EMPTY_BIT] = empty;
    s[3:0]              = count;
    return s;
  endfunction

endpackage

// File: rtl/port0_out_ctrl_fifo.sv
// rtl/port0_out_ctrl_fifo.sv - port_fifo: storage, wrapping pointers and occupancy count
module port_fifo #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Contents need no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/port0_out_ctrl.sv
// rtl/port0_out_ctrl.sv - port 0 output controller; optional sticky overflow via P0_OVERFLOW_FLAG_EN
module port0_out_ctrl
  import port0_out_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] bus_data_in,
  input  logic              wr_en,
  input  logic              p0_ack,
  output logic [WORD_W-1:0] p0_data_out,
  output logic              p0_valid,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] status_word
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              push;
  logic              clr_cmd;
  logic              ovf;

  assign pop  = !empty && (!p0_valid || p0_ack);
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push = wr_en && !clr_cmd && (!full || pop);

  port_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus_data_in),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_data_out <= '0;
      p0_valid    <= 1'b0;
    end else if (pop) begin
      p0_data_out <= head;
      p0_valid    <= 1'b1;
    end else if (p0_ack) begin
      p0_valid    <= 1'b0;
    end
  end

`ifdef P0_OVERFLOW_FLAG_EN
  // The clear word is a command, never data; it is only honoured with the FIFO empty.
  assign clr_cmd = wr_en && empty && (bus_data_in == WORD_W'(P0_CLR_OVF_WORD));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (clr_cmd) begin
      ovf <= 1'b0;
    end else if (wr_en && full && !pop) begin
      ovf <= 1'b1;
    end
  end
`else
  assign clr_cmd = 1'b0;
  assign ovf     = 1'b0;
`endif

  assign status_word = WORD_W'(pack_status(ovf, full, empty, 4'(count)));

endmodule

// File: tb/tb_port0_out_ctrl.sv
// tb/tb_port0_out_ctrl.sv - randomized and directed bench for port0_out_ctrl against a queue model
module tb_port0_out_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bus_data_in = '0;
  logic        wr_en = 1'b0;
  logic        p0_ack = 1'b0;
  logic [15:0] p0_data_out;
  logic        p0_valid;
  logic        full;
  logic        empty;
  logic [15:0] status_word;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] q[$];
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ovf;

`ifdef P0_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  port0_out_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus_data_in (bus_data_in),
    .wr_en       (wr_en),
    .p0_ack      (p0_ack),
    .p0_data_out (p0_data_out),
    .p0_valid    (p0_valid),
    .full        (full),
    .empty       (empty),
    .status_word (status_word)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  function automatic logic [15:0] exp_status();
    logic [15:0] s;
    s = '0;
    s[15] = m_ovf;
    s[5]  = (q.size() == DEPTH);
    s[4]  = (q.size() == 0);
    s[3:0] = 4'(q.size());
    return s;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"},  {15'd0, p0_valid}, {15'd0, m_valid});
    check({tag, ".data"},   p0_data_out, m_data);
    check({tag, ".full"},   {15'd0, full},  {15'd0, q.size() == DEPTH});
    check({tag, ".empty"},  {15'd0, empty}, {15'd0, q.size() == 0});
    check({tag, ".status"}, status_word, exp_status());
  endtask

  // Apply one cycle of stimulus, advance the model by the same rules, then compare.
  task automatic step(input string tag, input logic wr, input logic [15:0] d, input logic ack);
    bit do_pop, do_clr, do_drop;
    wr_en = wr;
    bus_data_in = d;
    p0_ack = ack;
    @(posedge clk);
    do_pop  = (q.size() > 0) && (!m_valid || ack);
    do_clr  = OVF_EN && wr && (d == 16'hFFFF) && (q.size() == 0);
    do_drop = wr && !do_clr && (q.size() == DEPTH) && !do_pop;
    if (do_pop) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end else if (ack) begin
      m_valid = 1'b0;
    end
    if (wr && !do_clr && !do_drop) q.push_back(d);
    if (do_drop && OVF_EN) m_ovf = 1'b1;
    if (do_clr) m_ovf = 1'b0;
    #1;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 3; i++) step(tag, 1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    model_reset();
    #12;
    rst = 1'b1;
    #1;
    check_all("reset");
    check("reset.status_lit", status_word, 16'h0010);

    // Single word, held, then consumed.
    step("single.wr", 1'b1, 16'hF0F0, 1'b0);
    for (int i = 0; i < 3; i++) step("single.hold", 1'b0, 16'h0, 1'b0);
    check("single.out", p0_data_out, 16'hF0F0);
    step("single.ack", 1'b0, 16'h0, 1'b1);
    check("single.keep", p0_data_out, 16'hF0F0);
    step("single.idle_ack", 1'b0, 16'h0, 1'b1);

    // Fill and overflow.
    for (int i = 1; i <= 6; i++) step("fill", 1'b1, 16'(i), 1'b0);
    check("fill.full", {15'd0, full}, 16'd1);
    check("fill.ovf", {15'd0, status_word[15]}, {15'd0, OVF_EN});
    drain("fill.drain");

`ifdef P0_OVERFLOW_FLAG_EN
    step("clr", 1'b1, 16'hFFFF, 1'b0);
    check("clr.ovf", {15'd0, status_word[15]}, 16'd0);
    step("clr.after", 1'b0, 16'h0, 1'b0);
`endif

    // Streaming with ack held high, enough cycles to wrap the pointers several times.
    for (int i = 0; i < 20; i++) step("stream", 1'b1, 16'(16'h100 + i), 1'b1);
    drain("stream.drain");

    // Push while full with ack.
    for (int i = 0; i < DEPTH + 1; i++) step("pf.fill", 1'b1, 16'(16'h200 + i), 1'b0);
    step("pf.push", 1'b1, 16'hABCD, 1'b1);
    check("pf.count", {12'd0, status_word[3:0]}, 16'(DEPTH));
    drain("pf.drain");
    check("pf.last", p0_data_out, 16'hABCD);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      step("rand", 1'($urandom_range(0, 2) != 0), d, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-run with words queued.
    for (int i = 0; i < 3; i++) step("prerst", 1'b1, 16'(16'h300 + i), 1'b0);
    rst = 1'b0;
    #2;
    model_reset();
    check_all("arst");
    check("arst.status_lit", status_word, 16'h0010);
    #9;
    rst = 1'b1;
    step("postrst", 1'b0, 16'h0, 1'b1);
    step("postrst.wr", 1'b1, 16'h5A5A, 1'b0);
    step("postrst.out", 1'b0, 16'h0, 1'b0);
    check("postrst.data", p0_data_out, 16'h5A5A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
